// File: rtl/rx_pkg.sv
// Shared types for the RX frame-sync path: FSM states, FIFO entry layout, default sync word.
package rx_pkg;
    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

    localparam int DIBIT_W = 2;

    typedef struct packed {
        logic               sof;
        logic               eof;
        logic [DIBIT_W-1:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    localparam logic [15:0] DEF_SYNC_WORD = 16'hA5C3;
endpackage

// File: rtl/rx_sym_fifo.sv
// Generic synchronous first-word-fall-through FIFO; head entry is visible on rd_data while !empty.
module rx_sym_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr, rd_ptr;
    logic                        wr_en, rd_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/rx_frame_sync.sv
// Integrate-and-dump QPSK slicer, sync-word search and framed payload delivery through an FWFT FIFO.
module rx_frame_sync
    import rx_pkg::*;
#(
    parameter int                    IN_W        = 6,
    parameter int                    SPS         = 4,
    parameter int                    SYNC_LEN    = 8,
    parameter logic [2*SYNC_LEN-1:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int                    PAYLOAD_LEN = 64,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                   CLK_2,
    input  logic                   RST,
    input  logic                   IN_VALID,
    input  logic signed [IN_W-1:0] I_CWM,
    input  logic signed [IN_W-1:0] Q_CWM,
    input  logic                   OUT_READY,
    output logic                   OUT_VALID,
    output logic [DIBIT_W-1:0]     OUT_DATA,
    output logic                   OUT_SOF,
    output logic                   OUT_EOF,
    output logic                   SYNC_LOCK,
    output logic                   OVERFLOW
);
    localparam int CW    = $clog2(SPS);
    localparam int ACC_W = IN_W + CW;
    localparam int FW    = $clog2(SYNC_LEN + 1);
    localparam int PW    = $clog2(PAYLOAD_LEN);

    logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
    logic [CW-1:0]           cnt;
    logic                    sym_stb;
    logic [DIBIT_W-1:0]      dibit;

    assign sum_i = acc_i + {{CW{I_CWM[IN_W-1]}}, I_CWM};
    assign sum_q = acc_q + {{CW{Q_CWM[IN_W-1]}}, Q_CWM};

    always_ff @(posedge CLK_2 or negedge RST) begin
        if (!RST) begin
            acc_i   <= '0;
            acc_q   <= '0;
            cnt     <= '0;
            sym_stb <= 1'b0;
            dibit   <= '0;
        end else begin
            sym_stb <= 1'b0;
            if (IN_VALID) begin
                if (cnt == CW'(SPS - 1)) begin
                    dibit   <= {~sum_i[ACC_W-1], ~sum_q[ACC_W-1]};
                    sym_stb <= 1'b1;
                    acc_i   <= '0;
                    acc_q   <= '0;
                    cnt     <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    cnt   <= cnt + 1'b1;
                end
            end
        end
    end

    state_e                state;
    logic [2*SYNC_LEN-1:0] sr, sr_nxt;
    logic [FW-1:0]         fill, fill_nxt;
    logic [PW-1:0]         pay_cnt;
    logic                  push, pop, full, empty;
    fifo_entry_t           push_entry, head;

    assign sr_nxt   = {sr[2*SYNC_LEN-3:0], dibit};
    assign fill_nxt = (fill == FW'(SYNC_LEN)) ? fill : fill + 1'b1;

    assign push            = sym_stb && (state == LOCKED);
    assign push_entry.sof  = (pay_cnt == '0);
    assign push_entry.eof  = (pay_cnt == PW'(PAYLOAD_LEN - 1));
    assign push_entry.data = dibit;

    always_ff @(posedge CLK_2 or negedge RST) begin
        if (!RST) begin
            state   <= SEARCH;
            sr      <= '0;
            fill    <= '0;
            pay_cnt <= '0;
        end else if (sym_stb) begin
            case (state)
                SEARCH: begin
                    sr   <= sr_nxt;
                    fill <= fill_nxt;
                    if (fill_nxt == FW'(SYNC_LEN) && sr_nxt == SYNC_WORD) begin
                        state   <= LOCKED;
                        pay_cnt <= '0;
                    end
                end
                LOCKED: begin
                    // pay_cnt advances even when the FIFO drops the entry, so framing stays intact.
                    pay_cnt <= pay_cnt + 1'b1;
                    if (push_entry.eof) begin
                        state <= SEARCH;
                        fill  <= '0;
                        sr    <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge CLK_2 or negedge RST) begin
        if (!RST)
            OVERFLOW <= 1'b0;
        else if (push && full && !pop)
            OVERFLOW <= 1'b1;
    end

    assign pop       = OUT_VALID && OUT_READY;
    assign OUT_VALID = !empty;
    assign OUT_DATA  = head.data;
    assign OUT_SOF   = head.sof;
    assign OUT_EOF   = head.eof;
    assign SYNC_LOCK = (state == LOCKED);

    rx_sym_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .gclk    (CLK_2),
        .grst_n  (RST),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );
endmodule
